cl_axi_mstr_cmd_arb: RTL

Round-robin arbiter and sequencer that shares the single-outstanding AXI master command engine (go/done, single 32-bit beat) among N_REQ independent requesters.
- Accepts one command from the granted requester and drives the engine go pulse.
- Waits for engine done and returns read data and response to that requester.
- Keeps a watchdog and status counters for host readback.
- Sits between requester logic (host cfg path, debug/trace units) and the AXI master engine.

---
 rtl/cl_axi_mstr_cmd_arb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cl_axi_mstr_cmd_arb.sv
// Round-robin arbiter that shares one single-outstanding AXI master command engine
// among N_REQ requesters, with a watchdog, sticky status flags and a completion counter.
module cl_axi_mstr_cmd_arb #(
  parameter  int N_REQ          = 4,
  parameter  int ADDR_W         = 64,
  parameter  int DATA_W         = 32,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int GW             = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_rd_wrb,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          resp_valid,
  input  logic [N_REQ-1:0]          resp_ready,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic                      eng_go,
  output logic                      eng_rd_wrb,
  output logic [ADDR_W-1:0]         eng_addr,
  output logic [DATA_W-1:0]         eng_wdata,
  input  logic                      eng_done,
  input  logic [DATA_W-1:0]         eng_rdata,
  input  logic [1:0]                eng_resp,
  output logic [GW-1:0]             cur_grant,
  output logic                      busy,
  output logic                      timeout_flag,
  output logic                      spurious_done,
  output logic [31:0]               cmd_count,
  input  logic                      clr_status
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q;
  logic [GW-1:0]     last_grant_q;
  logic [GW-1:0]     cur_grant_q;
  logic              eng_go_q;
  logic              eng_rd_wrb_q;
  logic [ADDR_W-1:0] eng_addr_q;
  logic [DATA_W-1:0] eng_wdata_q;
  logic [N_REQ-1:0]  resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;
  logic [WD_W-1:0]   wd_cnt_q;
  logic              timeout_flag_q;
  logic              spurious_q;
  logic [31:0]       cmd_count_q;

  logic [GW-1:0]     grant;
  logic [N_REQ-1:0]  grant_oh;
  int                scan_idx;
  logic              accept;
  logic              resp_hs;
  logic              set_timeout;
  logic              set_spurious;
  logic [31:0]       cmd_count_d;

  // Scan downward so the closest requester after last_grant is the one left in grant.
  always_comb begin
    grant    = '0;
    scan_idx = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      scan_idx = int'(last_grant_q) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (req_valid[GW'(scan_idx)]) grant = GW'(scan_idx);
    end
  end

  assign grant_oh     = N_REQ'(1) << grant;
  assign req_ready    = (aresetn && state_q == IDLE && |req_valid) ? grant_oh : '0;
  assign accept       = |(req_valid & req_ready);
  assign resp_hs      = (state_q == RESP) && |(resp_valid_q & resp_ready);
  assign set_timeout  = (state_q == WAIT) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign set_spurious = eng_done && (state_q != WAIT);
  assign cmd_count_d  = clr_status ? 32'd0 : (resp_hs ? cmd_count_q + 32'd1 : cmd_count_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      last_grant_q   <= GW'(N_REQ - 1);
      cur_grant_q    <= '0;
      eng_go_q       <= 1'b0;
      eng_rd_wrb_q   <= 1'b0;
      eng_addr_q     <= '0;
      eng_wdata_q    <= '0;
      resp_valid_q   <= '0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
      wd_cnt_q       <= '0;
      timeout_flag_q <= 1'b0;
      spurious_q     <= 1'b0;
      cmd_count_q    <= '0;
    end else begin
      eng_go_q       <= 1'b0;
      timeout_flag_q <= set_timeout | (timeout_flag_q & ~clr_status);
      spurious_q     <= set_spurious | (spurious_q & ~clr_status);
      cmd_count_q    <= cmd_count_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            eng_rd_wrb_q <= req_rd_wrb[grant];
            eng_addr_q   <= req_addr[int'(grant)*ADDR_W +: ADDR_W];
            eng_wdata_q  <= req_wdata[int'(grant)*DATA_W +: DATA_W];
            cur_grant_q  <= grant;
            eng_go_q     <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt_q <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          // An AXI transaction cannot be aborted, so the watchdog only saturates and flags.
          if (wd_cnt_q != WD_W'(TIMEOUT_CYCLES)) wd_cnt_q <= wd_cnt_q + 1'b1;
          if (eng_done) begin
            resp_rdata_q <= eng_rd_wrb_q ? eng_rdata : '0;
            resp_err_q   <= (eng_resp != 2'b00);
            resp_valid_q <= N_REQ'(1) << cur_grant_q;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_hs) begin
            resp_valid_q <= '0;
            last_grant_q <= cur_grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eng_go        = eng_go_q;
  assign eng_rd_wrb    = eng_rd_wrb_q;
  assign eng_addr      = eng_addr_q;
  assign eng_wdata     = eng_wdata_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign cur_grant     = cur_grant_q;
  assign busy          = (state_q != IDLE);
  assign timeout_flag  = timeout_flag_q;
  assign spurious_done = spurious_q;
  assign cmd_count     = cmd_count_q;

endmodule
